// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side UART frame controller.
//   Detects a start bit on the synchronized serial line, samples each bit
//   three times around its centre (ticks 7/8/9), resolves it by majority and
//   assembles DATA_BITS data bits LSB first, followed by one stop bit.
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset
//   sample_tick  - one-clk strobe, OVERSAMPLE per bit period
//   rx           - raw serial line (asynchronous, idle high)
//   rx_data      - last good byte, held until the next good frame
//   rx_valid     - one-clk pulse when rx_data is updated
//   frame_err    - one-clk pulse when the stop bit resolves to 0
//   busy         - high whenever the FSM is not idle
module uart_rx_ctrl #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sample_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 busy
);
   localparam int          IDX_W     = $clog2(DATA_BITS + 1);
   localparam logic [3:0]  LAST_TICK = 4'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t               state;
   logic                 rx_m, rx_s;
   logic [3:0]           tick_cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic                 s0, s1, s2;
   logic [DATA_BITS-1:0] shreg;
   logic                 maj, maj_stop;

   assign maj      = (s0 & s1) | (s1 & s2) | (s0 & s2);
   // Stop decision is taken on the tick that would capture s2, so the live
   // synchronized line stands in for s2.
   assign maj_stop = (s0 & s1) | (s1 & rx_s) | (s0 & rx_s);

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         bit_idx   <= '0;
         s0        <= 1'b0;
         s1        <= 1'b0;
         s2        <= 1'b0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         if (sample_tick) begin
            tick_cnt <= tick_cnt + 4'd1;   // wraps 15 -> 0 at end of bit
            if (tick_cnt == 4'd7) s0 <= rx_s;
            if (tick_cnt == 4'd8) s1 <= rx_s;
            if (tick_cnt == 4'd9) s2 <= rx_s;
            case (state)
               IDLE: begin
                  if (!rx_s) begin
                     // this tick is tick 0 of the start bit
                     state    <= START;
                     tick_cnt <= 4'd1;
                     busy     <= 1'b1;
                  end else begin
                     tick_cnt <= '0;
                  end
               end
               START: begin
                  if (tick_cnt == LAST_TICK) begin
                     if (maj) begin
                        state <= IDLE;       // false start, no pulse
                        busy  <= 1'b0;
                     end else begin
                        state   <= DATA;
                        bit_idx <= '0;
                     end
                  end
               end
               DATA: begin
                  if (tick_cnt == LAST_TICK) begin
                     shreg   <= {maj, shreg[DATA_BITS-1:1]};
                     bit_idx <= bit_idx + 1'b1;
                     if (bit_idx == LAST_BIT) state <= STOP;
                  end
               end
               STOP: begin
                  // Decide at mid-stop so a start edge right after the stop
                  // bit is seen from IDLE.
                  if (tick_cnt == 4'd9) begin
                     state    <= IDLE;
                     tick_cnt <= '0;
                     busy     <= 1'b0;
                     if (maj_stop) begin
                        rx_data  <= shreg;
                        rx_valid <= 1'b1;
                     end else begin
                        frame_err <= 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
